// File: rtl/regfile_np.sv
// Parametrised two-read-port register file with R0 accumulator moves, exchange, zero-load and soft-clear sweep.
// Optional same-edge write-to-read forwarding is enabled by defining REGFILE_NP_BYPASS_EN.
module regfile_np #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              we,
    input  logic [2:0]        mux_sel,
    input  logic [ADDR_W-1:0] write_seg,
    input  logic [ADDR_W-1:0] read_seg_a,
    input  logic [ADDR_W-1:0] read_seg_b,
    input  logic [DATA_W-1:0] OR2,
    input  logic [DATA_W-1:0] ALU_IN,
    input  logic              sclr_req,
    output logic              busy,
    output logic              wr_drop,
    output logic [DATA_W-1:0] dataout_A,
    output logic [DATA_W-1:0] dataout_B
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              mode_valid;
    logic              wr_ok;
    logic              wr_refused;
    logic [DATA_W-1:0] rd_a_p0;
    logic [DATA_W-1:0] rd_b_p0;

    assign mode_valid = (mux_sel <= 3'b101);
    assign wr_ok      = we && (state_q == IDLE) && mode_valid;
    assign wr_refused = we && (state_q == SWEEP) && mode_valid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sclr_req) state_d = SWEEP;
            SWEEP:   if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == SWEEP);
    end

    // Next array contents: every source reads pre-edge values, so the exchange is a true swap.
    always_comb begin
        mem_d = mem_q;
        if (wr_ok) begin
            case (mux_sel)
                3'b000: mem_d[write_seg] = mem_q[0];
                3'b001: mem_d[0]         = mem_q[write_seg];
                3'b010: mem_d[write_seg] = OR2;
                3'b011: mem_d[write_seg] = ALU_IN;
                3'b100: begin
                    mem_d[0]         = mem_q[write_seg];
                    mem_d[write_seg] = mem_q[0];
                end
                3'b101: mem_d[write_seg] = '0;
                default: ;
            endcase
        end
        if (state_q == SWEEP) mem_d[cnt_q] = '0;
    end

    always_comb begin
`ifdef REGFILE_NP_BYPASS_EN
        rd_a_p0 = mem_d[read_seg_a];
        rd_b_p0 = mem_d[read_seg_b];
`else
        rd_a_p0 = mem_q[read_seg_a];
        rd_b_p0 = mem_q[read_seg_b];
`endif
    end

    // p0 -> registered outputs
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_drop   <= 1'b0;
            dataout_A <= '0;
            dataout_B <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= (state_q == SWEEP) ? cnt_q + 1'b1 : '0;
            wr_drop   <= wr_refused;
            dataout_A <= rd_a_p0;
            dataout_B <= rd_b_p0;
            mem_q     <= mem_d;
        end
    end
endmodule

// File: tb/tb_regfile_np.sv
// Directed bench for regfile_np: default 8x8 instance plus a 16-bit, 16-entry instance.
module tb_regfile_np;
    logic       clk = 1'b0;
    logic       clr_n, we, sclr_req, busy, wr_drop;
    logic [2:0] mux_sel, write_seg, read_seg_a, read_seg_b;
    logic [7:0] OR2, ALU_IN, dataout_A, dataout_B;

    logic        clr_n16, we16, sclr16, busy16, drop16;
    logic [2:0]  mux16;
    logic [3:0]  wseg16, ra16, rb16;
    logic [15:0] or2_16, alu16, da16, db16;

    int n_chk = 0;
    int n_err = 0;
    int cycles;

    always #5 clk = ~clk;

    regfile_np u8 (
        .clk(clk), .clr_n(clr_n), .we(we), .mux_sel(mux_sel), .write_seg(write_seg),
        .read_seg_a(read_seg_a), .read_seg_b(read_seg_b), .OR2(OR2), .ALU_IN(ALU_IN),
        .sclr_req(sclr_req), .busy(busy), .wr_drop(wr_drop),
        .dataout_A(dataout_A), .dataout_B(dataout_B)
    );

    regfile_np #(.DATA_W(16), .ADDR_W(4)) u16 (
        .clk(clk), .clr_n(clr_n16), .we(we16), .mux_sel(mux16), .write_seg(wseg16),
        .read_seg_a(ra16), .read_seg_b(rb16), .OR2(or2_16), .ALU_IN(alu16),
        .sclr_req(sclr16), .busy(busy16), .wr_drop(drop16),
        .dataout_A(da16), .dataout_B(db16)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] m, input logic [2:0] s, input logic [7:0] o, input logic [7:0] a);
        we = 1'b1; mux_sel = m; write_seg = s; OR2 = o; ALU_IN = a;
        step();
        we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [2:0] b);
        read_seg_a = a; read_seg_b = b;
        step();
    endtask

    task automatic load16();
        for (int i = 0; i < 16; i++) begin
            we16 = 1'b1; mux16 = 3'b010; wseg16 = 4'(i); or2_16 = 16'h1000 + 16'(i);
            step();
        end
        we16 = 1'b0;
    endtask

    initial begin
        clr_n = 1'b0; we = 1'b0; sclr_req = 1'b0; mux_sel = '0; write_seg = '0;
        read_seg_a = '0; read_seg_b = '0; OR2 = '0; ALU_IN = '0;
        clr_n16 = 1'b0; we16 = 1'b0; sclr16 = 1'b0; mux16 = '0; wseg16 = '0;
        ra16 = '0; rb16 = '0; or2_16 = '0; alu16 = '0;
        step(); step();
        clr_n = 1'b1; clr_n16 = 1'b1;
        step();

        // Mid-run reset clears outputs immediately
        wr(3'b010, 3'd3, 8'hFF, 8'h00);
        rd(3'd3, 3'd3);
        chk("pre_reset_A", dataout_A, 16'h00FF);
        #2 clr_n = 1'b0;
        #1;
        chk("async_rst_A", dataout_A, 16'h0000);
        chk("async_rst_B", dataout_B, 16'h0000);
        step();
        clr_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), 3'(7 - i));
            chk("rst_entry_A", dataout_A, 16'h0000);
            chk("rst_entry_B", dataout_B, 16'h0000);
        end
        chk("rst_busy", busy, 16'h0);
        chk("rst_drop", wr_drop, 16'h0);

        // ALU write then read on port B
        wr(3'b011, 3'd3, 8'h5A, 8'hA5);
        rd(3'd0, 3'd3);
        chk("alu_wr_B", dataout_B, 16'h00A5);

        // Exchange, and exchange with N=0
        wr(3'b010, 3'd0, 8'h11, 8'hEE);
        wr(3'b010, 3'd5, 8'h22, 8'hEE);
        wr(3'b100, 3'd5, 8'h00, 8'h00);
        rd(3'd0, 3'd5);
        chk("xchg_R0", dataout_A, 16'h0022);
        chk("xchg_R5", dataout_B, 16'h0011);
        wr(3'b100, 3'd0, 8'h00, 8'h00);
        rd(3'd0, 3'd5);
        chk("xchg0_R0", dataout_A, 16'h0022);

        // RN<-R0, R0<-RN, RN<-0, reserved code
        wr(3'b000, 3'd6, 8'h00, 8'h00);
        wr(3'b010, 3'd1, 8'h44, 8'h00);
        wr(3'b001, 3'd1, 8'h00, 8'h00);
        rd(3'd6, 3'd0);
        chk("rn_from_r0", dataout_A, 16'h0022);
        chk("r0_from_rn", dataout_B, 16'h0044);
        wr(3'b101, 3'd6, 8'h00, 8'h00);
        wr(3'b110, 3'd1, 8'h99, 8'h99);
        chk("rsvd_nodrop", wr_drop, 16'h0);
        rd(3'd6, 3'd1);
        chk("zero_load", dataout_A, 16'h0000);
        chk("rsvd_nowr", dataout_B, 16'h0044);

        // Same-cycle read and write
        wr(3'b010, 3'd2, 8'h01, 8'h00);
        read_seg_a = 3'd2;
        wr(3'b010, 3'd2, 8'h7E, 8'h00);
`ifdef REGFILE_NP_BYPASS_EN
        chk("same_cycle_A", dataout_A, 16'h007E);
`else
        chk("same_cycle_A", dataout_A, 16'h0001);
`endif
        rd(3'd2, 3'd2);
        chk("after_wr_A", dataout_A, 16'h007E);

        // Soft-clear sweep with a refused write in the middle
        for (int i = 0; i < 8; i++) wr(3'b010, 3'(i), 8'h10 + 8'(i), 8'h00);
        sclr_req = 1'b1;
        step();
        sclr_req = 1'b0;
        chk("sweep_busy0", busy, 16'h1);
        for (int k = 0; k < 8; k++) begin
            read_seg_a = (k == 0) ? 3'd0 : 3'(k - 1);
            read_seg_b = (k < 7) ? 3'(k + 1) : 3'd7;
            if (k == 2) begin
                we = 1'b1; mux_sel = 3'b010; OR2 = 8'h3C; write_seg = 3'd7;
            end
            step();
            we = 1'b0;
            chk("sweep_busy", busy, (k < 7) ? 16'h1 : 16'h0);
            chk("sweep_drop", wr_drop, (k == 2) ? 16'h1 : 16'h0);
            if (k >= 1) chk("sweep_cleared", dataout_A, 16'h0000);
            if (k < 7) chk("sweep_pending", dataout_B, 16'h0010 + 16'(k + 1));
        end
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), 3'd7);
            chk("post_sweep", dataout_A, 16'h0000);
        end
        chk("post_sweep_R7", dataout_B, 16'h0000);

        // 16-bit / 16-entry variant: reset mid-sweep, then a full sweep
        load16();
        ra16 = 4'd10;
        sclr16 = 1'b1;
        step();
        sclr16 = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("v_busy_mid", busy16, 16'h1);
        chk("v_pending", da16, 16'h100A);
        clr_n16 = 1'b0;
        #1;
        chk("v_rst_busy", busy16, 16'h0);
        chk("v_rst_A", da16, 16'h0000);
        step();
        clr_n16 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ra16 = 4'(i); rb16 = 4'(15 - i);
            step();
            chk("v_rst_entry", da16 | db16, 16'h0000);
        end
        load16();
        ra16 = 4'd15;
        step();
        chk("v_loaded", da16, 16'h100F);
        sclr16 = 1'b1;
        step();
        sclr16 = 1'b0;
        cycles = 0;
        for (int c = 0; c < 40; c++) begin
            if (!busy16) break;
            cycles++;
            step();
        end
        chk("v_busy_len", 16'(cycles), 16'd16);
        for (int i = 0; i < 16; i++) begin
            ra16 = 4'(i);
            step();
            chk("v_post_sweep", da16, 16'h0000);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
